// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder into a one-entry output register (1-cycle latency); in_ready falls only while a word is held and out_ready is low.
// Define RV_ENC_RANGE_CHECK_EN to reject out-of-range or misaligned immediates instead of truncating them.
module rv32i_inst_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       inst_count
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3;
  logic [31:0] enc_inst;
  logic        illegal;
  logic [1:0]  enc_err;
  logic        accept, load, handoff;

  always_comb begin
    case (op_sel)
      6'd2, 6'd11, 6'd20, 6'd25, 6'd28:        f3 = 3'd1;
      6'd3, 6'd12, 6'd21, 6'd26:               f3 = 3'd2;
      6'd4, 6'd13:                             f3 = 3'd3;
      6'd5, 6'd14, 6'd22, 6'd29:               f3 = 3'd4;
      6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30:  f3 = 3'd5;
      6'd8, 6'd17, 6'd31:                      f3 = 3'd6;
      6'd9, 6'd18, 6'd32:                      f3 = 3'd7;
      default:                                 f3 = 3'd0;
    endcase
  end

  always_comb begin
    enc_inst = '0;
    illegal  = 1'b0;
    case (op_sel) inside
      [6'd0:6'd9]:
        enc_inst = {(op_sel == 6'd1 || op_sel == 6'd7) ? F7_ALT : 7'd0, rs2, rs1, f3, rd, OPC_R};
      6'd11, 6'd15, 6'd16:
        enc_inst = {(op_sel == 6'd16) ? F7_ALT : 7'd0, imm[4:0], rs1, f3, rd, OPC_ALUI};
      6'd10, 6'd12, 6'd13, 6'd14, 6'd17, 6'd18:
        enc_inst = {imm[11:0], rs1, f3, rd, OPC_ALUI};
      [6'd19:6'd23]:
        enc_inst = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      [6'd24:6'd26]:
        enc_inst = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      [6'd27:6'd32]:
        enc_inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      6'd33:   enc_inst = {imm[19:0], rd, OPC_LUI};
      6'd34:   enc_inst = {imm[19:0], rd, OPC_AUIPC};
      6'd35:   enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      6'd36:   enc_inst = {imm[11:0], rs1, f3, rd, OPC_JALR};
      default: illegal = 1'b1;
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  logic fits_i, fits_b, fits_j, misaligned, out_of_range;

  // A signed value fits N bits when every bit from N-1 upward matches the sign.
  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_j = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (op_sel) inside
      6'd11, 6'd15, 6'd16: out_of_range = |imm[31:5];
      6'd10, 6'd12, 6'd13, 6'd14, 6'd17, 6'd18, [6'd19:6'd26], 6'd36:
        out_of_range = ~fits_i;
      [6'd27:6'd32]: begin
        misaligned   = imm[0];
        out_of_range = ~fits_b;
      end
      6'd33, 6'd34: out_of_range = |imm[31:20];
      6'd35: begin
        misaligned   = imm[0];
        out_of_range = ~fits_j;
      end
      default: ;
    endcase
  end

  assign enc_err = illegal      ? 2'b01 :
                   misaligned   ? 2'b11 :
                   out_of_range ? 2'b10 : 2'b00;
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign enc_err       = illegal ? 2'b01 : 2'b00;
`endif

  assign out_valid = (state == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept && enc_err == 2'b00) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (accept && enc_err == 2'b00) load = 1'b1;
          else                            state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      out_inst   <= '0;
      out_addr   <= ADDR_BASE;
      err_valid  <= 1'b0;
      err_code   <= 2'b00;
      inst_count <= '0;
    end else begin
      state <= state_nxt;
      if (load) out_inst <= enc_inst;
      if (handoff) begin
        out_addr   <= out_addr + ADDR_W'(4);
        inst_count <= inst_count + 16'd1;
      end
      // Rejected requests are consumed but only surface as a one-cycle error pulse.
      err_valid <= accept & (enc_err != 2'b00);
      err_code  <= accept ? enc_err : 2'b00;
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder; expectations follow the build's RV_ENC_RANGE_CHECK_EN setting.
module tb_rv32i_inst_encoder;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] inst_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_addr  = 32'h0;
  logic [15:0] exp_count = 16'h0;

  rv32i_inst_encoder #(.ADDR_W(32), .ADDR_BASE(32'h0)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .inst_count(inst_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef RV_ENC_RANGE_CHECK_EN
  // Misalignment outranks range; each format has its own legal window.
  function automatic logic [1:0] range_err(input int op, input logic [31:0] im);
    int v;
    v = $signed(im);
    if (((op >= 27 && op <= 32) || op == 35) && im[0]) return 2'b11;
    if (op == 11 || op == 15 || op == 16) return (v < 0 || v > 31) ? 2'b10 : 2'b00;
    if ((op >= 10 && op <= 26) || op == 36) return (v < -2048 || v > 2047) ? 2'b10 : 2'b00;
    if (op >= 27 && op <= 32) return (v < -4096 || v > 4094) ? 2'b10 : 2'b00;
    if (op == 33 || op == 34) return (im > 32'h000F_FFFF) ? 2'b10 : 2'b00;
    if (op == 35) return (v < -1048576 || v > 1048574) ? 2'b10 : 2'b00;
    return 2'b00;
  endfunction
`endif

  function automatic void ref_encode(input int op, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [31:0] im,
                                     output logic [31:0] inst, output logic [1:0] err);
    int f3s [37] = '{0,0,1,2,3,4,5,5,6,7, 0,1,2,3,4,5,5,6,7, 0,1,2,4,5, 0,1,2,
                     0,1,4,5,6,7, 0,0,0,0};
    int f3v;
    logic [2:0] f3;
    inst = 32'h0;
    err  = 2'b00;
    if (op < 0 || op > 36) begin
      err = 2'b01;
      return;
    end
    f3v = f3s[op];
    f3  = f3v[2:0];
    if (op <= 9)
      inst = {(op == 1 || op == 7) ? 7'h20 : 7'h00, s2, s1, f3, d, 7'h33};
    else if (op == 11 || op == 15 || op == 16)
      inst = {(op == 16) ? 7'h20 : 7'h00, im[4:0], s1, f3, d, 7'h13};
    else if (op <= 23 || op == 36)
      inst = {im[11:0], s1, f3, d, (op <= 18) ? 7'h13 : (op <= 23) ? 7'h03 : 7'h67};
    else if (op <= 26)
      inst = {im[11:5], s2, s1, f3, im[4:0], 7'h23};
    else if (op <= 32)
      inst = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
    else if (op <= 34)
      inst = {im[19:0], d, (op == 33) ? 7'h37 : 7'h17};
    else
      inst = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
`ifdef RV_ENC_RANGE_CHECK_EN
    err = range_err(op, im);
`endif
  endfunction

  task automatic drive_req(input int op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1;
    op_sel   = op[5:0];
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
  endtask

  task automatic push_exp(input logic [31:0] inst);
    exp_inst_q.push_back(inst);
    exp_addr_q.push_back(exp_addr);
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic pop_exp(output logic [31:0] e_inst, output logic [31:0] e_addr);
    if (exp_inst_q.size() == 0) begin
      e_inst = 'x;
      e_addr = 'x;
    end else begin
      e_inst = exp_inst_q.pop_front();
      e_addr = exp_addr_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    n_cmp++; if (out_addr !== 32'h0) begin n_bad++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    n_cmp++; if (err_valid !== 1'b0 || err_code !== 2'b00) begin
      n_bad++; $display("FAIL reset_err: got %b/%b want 0/00", err_valid, err_code);
    end
    n_cmp++; if (inst_count !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", inst_count); end
    reset = 1'b0;
    exp_addr = 32'h0; exp_count = 16'h0;
  endtask

  task automatic test_back_to_back();
    int          ops  [5] = '{0, 1, 10, 27, 35};
    logic [4:0]  rds  [5] = '{5'd3, 5'd5, 5'd1, 5'd0, 5'd0};
    logic [4:0]  r1s  [5] = '{5'd1, 5'd6, 5'd0, 5'd1, 5'd0};
    logic [4:0]  r2s  [5] = '{5'd2, 5'd7, 5'd0, 5'd2, 5'd0};
    logic [31:0] imms [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd8, 32'd4};
    logic [31:0] want [5] = '{32'h002081B3, 32'h407302B3, 32'hFFF00093, 32'h00208463, 32'h0040006F};
    logic [31:0] e_i, e_a;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clock);
      out_ready = 1'b1;
      n_cmp++; if (inst_count !== exp_count) begin
        n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, inst_count, exp_count);
      end
      n_cmp++; if (out_valid !== (i > 0)) begin
        n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, i > 0);
      end
      if (out_valid) begin
        pop_exp(e_i, e_a);
        n_cmp++; if (out_inst !== e_i || out_addr !== e_a) begin
          n_bad++; $display("FAIL b2b_word[%0d]: got %h@%h want %h@%h", i, out_inst, out_addr, e_i, e_a);
        end
        exp_count++;
      end
      if (i < 5) begin
        drive_req(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
        push_exp(want[i]);
      end else in_valid = 1'b0;
    end
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || inst_count !== exp_count || exp_inst_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_drain: valid %b count %0d want 0/%0d", out_valid, inst_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a_i, b_i, e_i, e_a;
    logic [1:0]  a_e, b_e;
    ref_encode(26, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, a_i, a_e);
    ref_encode(33, 5'd7, 5'd0, 5'd0, 32'h0001_2345, b_i, b_e);
    @(negedge clock);
    out_ready = 1'b0;
    drive_req(26, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
    push_exp(a_i);
    @(negedge clock);
    drive_req(33, 5'd7, 5'd0, 5'd0, 32'h0001_2345);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL bp_stall[%0d]: in_ready %b out_valid %b want 0/1", c, in_ready, out_valid);
      end
      n_cmp++; if (exp_inst_q.size() != 1 || out_inst !== exp_inst_q[0] || out_addr !== exp_addr_q[0]) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got %h@%h", c, out_inst, out_addr);
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    pop_exp(e_i, e_a);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== e_i || out_addr !== e_a) begin
      n_bad++; $display("FAIL bp_first: got %b %h@%h want 1 %h@%h", out_valid, out_inst, out_addr, e_i, e_a);
    end
    exp_count++;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: in_ready %b want 1", in_ready); end
    push_exp(b_i);
    @(negedge clock);
    in_valid = 1'b0;
    pop_exp(e_i, e_a);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== e_i || out_addr !== e_a) begin
      n_bad++; $display("FAIL bp_second: got %b %h@%h want 1 %h@%h", out_valid, out_inst, out_addr, e_i, e_a);
    end
    exp_count++;
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b0 || inst_count !== exp_count) begin
      n_bad++; $display("FAIL bp_drain: valid %b count %0d want 0/%0d", out_valid, inst_count, exp_count);
    end
  endtask

  task automatic test_illegal();
    int bad_ops [3] = '{40, 37, 63};
    foreach (bad_ops[k]) begin
      @(negedge clock);
      out_ready = 1'b1;
      drive_req(bad_ops[k], 5'd1, 5'd2, 5'd3, 32'd4);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++; if (err_valid !== 1'b1 || err_code !== 2'b01 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL illegal_pulse[%0d]: err %b/%b out_valid %b want 1/01/0", bad_ops[k], err_valid, err_code, out_valid);
      end
      @(negedge clock);
      n_cmp++; if (err_valid !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL illegal_end[%0d]: err_valid %b out_valid %b want 0/0", bad_ops[k], err_valid, out_valid);
      end
      n_cmp++; if (out_addr !== exp_addr || inst_count !== exp_count) begin
        n_bad++; $display("FAIL illegal_state[%0d]: addr %h count %0d want %h/%0d", bad_ops[k], out_addr, inst_count, exp_addr, exp_count);
      end
    end
  endtask

  task automatic test_range();
    int          ops  [22] = '{10, 28, 28, 10, 10, 10, 11, 11, 16, 24, 24, 27, 27, 27, 27, 35, 35, 35, 35, 33, 33, 36};
    logic [31:0] imms [22] = '{32'd2048, 32'd6, 32'd5, 32'd2047, -32'sd2048, -32'sd2049, 32'd31, 32'd32,
                               32'hFFFF_FFFF, -32'sd2048, 32'd2048, 32'd4094, 32'd4096, -32'sd4096, 32'd4095,
                               32'd1048574, 32'd1048576, -32'sd1048576, 32'd3, 32'h000F_FFFF, 32'h0010_0000, -32'sd1};
`ifdef RV_ENC_RANGE_CHECK_EN
    logic [31:0] spec_inst [3] = '{32'h0, 32'h00209363, 32'h0};
    logic [1:0]  spec_err  [3] = '{2'b10, 2'b00, 2'b11};
`else
    logic [31:0] spec_inst [3] = '{32'h80000013, 32'h00209363, 32'h00209263};
    logic [1:0]  spec_err  [3] = '{2'b00, 2'b00, 2'b00};
`endif
    logic [31:0] e_inst, e_i, e_a;
    logic [1:0]  e_err;
    logic [4:0]  d, s1, s2;
    for (int i = 0; i < 22; i++) begin
      d  = (i < 3) ? 5'd0 : 5'd1;
      s1 = (i < 3) ? ((i == 0) ? 5'd0 : 5'd1) : 5'd2;
      s2 = (i < 3) ? ((i == 0) ? 5'd0 : 5'd2) : 5'd3;
      if (i < 3) begin
        e_inst = spec_inst[i];
        e_err  = spec_err[i];
      end else ref_encode(ops[i], d, s1, s2, imms[i], e_inst, e_err);
      @(negedge clock);
      out_ready = 1'b1;
      drive_req(ops[i], d, s1, s2, imms[i]);
      if (e_err == 2'b00) push_exp(e_inst);
      @(negedge clock);
      in_valid = 1'b0;
      n_cmp++; if (err_valid !== (e_err != 2'b00) || out_valid !== (e_err == 2'b00)) begin
        n_bad++; $display("FAIL range_flags[%0d]: err_valid %b out_valid %b want %b/%b", i, err_valid, out_valid, e_err != 2'b00, e_err == 2'b00);
      end
      if (e_err != 2'b00) begin
        n_cmp++; if (err_code !== e_err) begin
          n_bad++; $display("FAIL range_code[%0d]: got %b want %b", i, err_code, e_err);
        end
      end else begin
        pop_exp(e_i, e_a);
        n_cmp++; if (out_inst !== e_i || out_addr !== e_a) begin
          n_bad++; $display("FAIL range_word[%0d]: got %h@%h want %h@%h", i, out_inst, out_addr, e_i, e_a);
        end
        exp_count++;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_random(input int n);
    int          sent = 0;
    logic        exp_full = 1'b0, nxt_full, acc = 1'b0, acc_prev = 1'b0, done = 1'b0;
    logic        ev = 1'b0;
    logic [1:0]  ec = 2'b00, m_err;
    logic [31:0] m_inst, e_i, e_a, r_imm;
    int          r_op;
    logic [4:0]  r_d, r_s1, r_s2;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clock);
      n_cmp++; if (err_valid !== ev || (ev && err_code !== ec)) begin
        n_bad++; $display("FAIL rnd_err[%0d]: got %b/%b want %b/%b", cyc, err_valid, err_code, ev, ec);
      end
      n_cmp++; if (out_valid !== exp_full || inst_count !== exp_count) begin
        n_bad++; $display("FAIL rnd_state[%0d]: valid %b count %0d want %b/%0d", cyc, out_valid, inst_count, exp_full, exp_count);
      end
      if (acc_prev) in_valid = 1'b0;
      if (sent >= n && !exp_full && !in_valid) begin
        done = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (exp_full && out_ready) begin
          pop_exp(e_i, e_a);
          n_cmp++; if (out_inst !== e_i || out_addr !== e_a) begin
            n_bad++; $display("FAIL rnd_word[%0d]: got %h@%h want %h@%h", cyc, out_inst, out_addr, e_i, e_a);
          end
          exp_count++;
        end
        if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
          r_op = $urandom_range(0, 40);
          r_d = 5'($urandom); r_s1 = 5'($urandom); r_s2 = 5'($urandom);
          case ($urandom_range(0, 2))
            0: r_imm = 32'($urandom_range(0, 80)) - 32'd40;
            1: r_imm = $urandom;
            default: begin r_imm = $urandom; r_imm[31:13] = {19{r_imm[12]}}; end
          endcase
          drive_req(r_op, r_d, r_s1, r_s2, r_imm);
        end
        acc = in_valid && (!exp_full || out_ready);
        #1;
        n_cmp++; if (in_ready !== (!exp_full || out_ready)) begin
          n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, in_ready, !exp_full || out_ready);
        end
        ev = 1'b0; ec = 2'b00;
        nxt_full = exp_full && !out_ready;
        if (acc) begin
          ref_encode(r_op, r_d, r_s1, r_s2, r_imm, m_inst, m_err);
          sent++;
          if (m_err != 2'b00) begin ev = 1'b1; ec = m_err; end
          else begin push_exp(m_inst); nxt_full = 1'b1; end
        end
        exp_full = nxt_full;
        acc_prev = acc;
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL rnd_timeout: sent %0d of %0d", sent, n); end
  endtask

  task automatic test_reset_while_full();
    logic [31:0] a_i, e_i, e_a;
    logic [1:0]  a_e;
    @(negedge clock);
    out_ready = 1'b0;
    drive_req(5, 5'd9, 5'd10, 5'd11, 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_full_pre: out_valid %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || inst_count !== 16'h0) begin
      n_bad++; $display("FAIL rst_full_post: valid %b addr %h count %0d want 0/0/0", out_valid, out_addr, inst_count);
    end
    exp_inst_q.delete(); exp_addr_q.delete();
    exp_addr = 32'h0; exp_count = 16'h0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      n_cmp++; if (out_valid !== 1'b0 || inst_count !== 16'h0) begin
        n_bad++; $display("FAIL rst_discard: valid %b count %0d want 0/0", out_valid, inst_count);
      end
    end
    ref_encode(9, 5'd4, 5'd5, 5'd6, 32'd0, a_i, a_e);
    drive_req(9, 5'd4, 5'd5, 5'd6, 32'd0);
    push_exp(a_i);
    @(negedge clock);
    in_valid = 1'b0;
    pop_exp(e_i, e_a);
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== e_i || out_addr !== e_a) begin
      n_bad++; $display("FAIL rst_first_word: got %b %h@%h want 1 %h@%h", out_valid, out_inst, out_addr, e_i, e_a);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_range();
    test_random(300);
    test_reset_while_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
